// File: rtl/sseg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sseg_pkg                                                         |
// | Shared types, constants and hex-to-segment decode table for the  |
// | seven-segment refresh scheduler.                                 |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package sseg_pkg;

  typedef logic [3:0] hex_t;
  // Active-low cathodes, bit order {g,f,e,d,c,b,a}
  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  function automatic seg_t hex2seg(input hex_t hex);
    seg_t seg;
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_scan_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sseg_scan_ctrl_if                                                |
// | Digit write port plus display pins of the scan controller.       |
// | master: application side, slave: scan controller.                |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
interface sseg_scan_ctrl_if;

  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_digits;
  logic [3:0]  wr_enable;
  logic        frame_start;
  logic [3:0]  sseg_an;
  logic [6:0]  sseg_ca;

  modport master (
    output wr_valid, wr_digits, wr_enable,
    input  wr_ready, frame_start, sseg_an, sseg_ca
  );

  modport slave (
    input  wr_valid, wr_digits, wr_enable,
    output wr_ready, frame_start, sseg_an, sseg_ca
  );

endinterface
`default_nettype wire

// File: rtl/sseg_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sseg_decoder                                                     |
// | Combinational hex digit to active-low segment pattern.           |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module sseg_decoder
  import sseg_pkg::*;
(
  input  hex_t hex,
  output seg_t seg
);

  assign seg = hex2seg(hex);

endmodule
`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sseg_scan_ctrl                                                   |
// | 4-digit seven-segment refresh scheduler with per-slot blanking   |
// | and frame-aligned commit of digit updates.                       |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  sseg_scan_ctrl_if.slave   bus
);

  localparam int             CW        = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CW-1:0]  CNT_MAX   = CW'(TICKS_PER_DIGIT - 1);
  // One extra bit so the comparison stays exact when BLANK_TICKS is near the top of the range
  localparam logic [CW:0]    BLANK_LIM = (CW + 1)'(BLANK_TICKS);

  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic          pending;
  logic [15:0]   sh_digits;
  logic [3:0]    sh_enable;
  logic [15:0]   disp_digits;
  logic [3:0]    disp_enable;
  logic [3:0]    an_q;
  seg_t          ca_q;
  logic          frame_q;

  logic          at_wrap;
  logic          boundary;
  logic          accept;
  logic          blanked;
  hex_t          sel_hex;
  seg_t          sel_seg;
  logic [3:0]    an_next;
  seg_t          ca_next;

  // Single-entry shadow: refuse further writes until the pending one has been committed
  assign bus.wr_ready = ~pending & ~rst;
  assign accept       = bus.wr_valid & bus.wr_ready;

  assign at_wrap  = (cnt == CNT_MAX);
  assign boundary = at_wrap && (slot == 2'd3);

  assign sel_hex = disp_digits[{slot, 2'b00} +: 4];

  sseg_decoder u_decoder (
    .hex (sel_hex),
    .seg (sel_seg)
  );

  // Next pin state: dark during the blanking window or when the slot's digit is disabled
  always_comb begin
    blanked = ({1'b0, cnt} < BLANK_LIM) || !disp_enable[slot];
    an_next = AN_OFF;
    ca_next = SEG_OFF;
    if (!blanked) begin
      an_next = ~(4'b0001 << slot);
      ca_next = sel_seg;
    end
  end

  // Scan counters, shadow capture, frame-boundary commit and registered pin drive
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      slot        <= 2'd0;
      pending     <= 1'b0;
      sh_digits   <= '0;
      sh_enable   <= '0;
      disp_digits <= '0;
      disp_enable <= '0;
      an_q        <= AN_OFF;
      ca_q        <= SEG_OFF;
      frame_q     <= 1'b0;
    end else begin
      if (at_wrap) begin
        cnt  <= '0;
        slot <= slot + 2'd1;
      end else begin
        cnt  <= cnt + 1'b1;
      end

      // Commit uses the registered flag, so a write landing on the boundary waits a frame
      if (boundary && pending) begin
        disp_digits <= sh_digits;
        disp_enable <= sh_enable;
        pending     <= 1'b0;
      end

      // accept implies pending is clear, so it never collides with the commit above
      if (accept) begin
        sh_digits <= bus.wr_digits;
        sh_enable <= bus.wr_enable;
        pending   <= 1'b1;
      end

      an_q    <= an_next;
      ca_q    <= ca_next;
      frame_q <= (slot == 2'd0) && (cnt == '0);
    end
  end

  assign bus.sseg_an     = an_q;
  assign bus.sseg_ca     = ca_q;
  assign bus.frame_start = frame_q;

endmodule
`default_nettype wire
